// File: rtl/pop_scheduler_pkg.sv
// Shared constants and state encoding for the pop scheduler and its arbiter.
`ifndef POP_SCHEDULER_PKG_SV
`define POP_SCHEDULER_PKG_SV
package pop_scheduler_pkg;
    localparam int N_SRC  = 4;
    localparam int DW_DEF = 6;
    localparam int TW     = 4;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } estado_t;
endpackage
`endif

// File: rtl/pop_scheduler_rr_arbiter.sv
// Round-robin grant: first requesting, unmasked index strictly after the last
// granted one, wrapping modulo N.
module rr_arbiter
    import pop_scheduler_pkg::*;
#(
    parameter int N  = N_SRC,
    parameter int IW = (N > 1) ? $clog2(N) : 1
)
(
    input  logic [N-1:0]  request,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant
);
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && request[idx] && !mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pop_scheduler.sv
// Pops N source FIFOs round-robin and forwards each returned word to one
// downstream FIFO, with threshold broadcast and a sticky error state.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RESET  | just out of reset, moves to INIT on the first clock
// ST_INIT   | capturing thresholds while init=1
// ST_IDLE   | configured, nothing to pop or downstream paused
// ST_ACTIVE | issuing round-robin pops
// ST_ERROR  | a source flagged an error; sticky until reset
module pop_scheduler
    import pop_scheduler_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_SRC
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic [3:0]      umbral_af_in,
    input  logic [3:0]      umbral_ae_in,
    input  logic [N-1:0]    fifo_empty,
    input  logic [N-1:0]    fifo_error,
    input  logic [N*DW-1:0] data_in,
    input  logic [N-1:0]    valid_in,
    input  logic            out_pause,
    output logic [N-1:0]    pop,
    output logic            push_out,
    output logic [DW-1:0]   data_out,
    output logic [3:0]      umbral_af_out,
    output logic [3:0]      umbral_ae_out,
    output logic [4:0]      estado,
    output logic            error_out,
    output logic            idle
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    estado_t       state, state_nxt;
    logic          captured;
    logic [N-1:0]  pend, grant, hit, req;
    logic [IW-1:0] last, pop_idx, hit_idx;
    logic          any_err, any_ready;

    assign req       = ~fifo_empty;
    assign any_err   = |fifo_error;
    assign any_ready = |req;
    assign hit       = valid_in & pend;

    // Last cycle's pop is masked so its empty flag has a cycle to settle.
    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .request (req),
        .mask    (pend),
        .last    (last),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // ACTIVE is held through the settle gap so a lone source keeps its cadence.
    always_comb begin
        state_nxt = state;
        pop       = '0;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT: begin
                if (any_err)                state_nxt = ST_ERROR;
                else if (!init && captured) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_err)                     state_nxt = ST_ERROR;
                else if (!out_pause && any_ready) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)                      state_nxt = ST_ERROR;
                else if (out_pause || !any_ready) state_nxt = ST_IDLE;
                if (!out_pause && !any_err)       pop = grant;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        pop_idx = '0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) pop_idx = IW'(i);
            if (hit[i]) hit_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured      <= 1'b0;
            umbral_af_out <= '0;
            umbral_ae_out <= '0;
            last          <= IW'(N - 1);
            pend          <= '0;
            push_out      <= 1'b0;
            data_out      <= '0;
        end else begin
            if (state == ST_INIT && init) begin
                umbral_af_out <= umbral_af_in;
                umbral_ae_out <= umbral_ae_in;
                captured      <= 1'b1;
            end
            if (state_nxt == ST_ERROR) begin
                pend     <= '0;
                push_out <= 1'b0;
            end else begin
                pend     <= pop;
                push_out <= |hit;
                if (|hit) data_out <= data_in[int'(hit_idx)*DW +: DW];
            end
            if (|pop) last <= pop_idx;
        end
    end

    assign estado    = state;
    assign error_out = (state == ST_ERROR);
    assign idle      = (state == ST_IDLE);
endmodule

// File: tb/tb_pop_scheduler.sv
// Directed bench for pop_scheduler: reset, init, round-robin, settle gap,
// pause, stray valid, error and asynchronous reset.
module tb_pop_scheduler;
    logic        clk;
    logic        reset;
    logic        init;
    logic [3:0]  umbral_af_in, umbral_ae_in;
    logic [3:0]  fifo_empty, fifo_error;
    logic [23:0] data_in;
    logic [3:0]  valid_in;
    logic        out_pause;
    logic [3:0]  pop;
    logic        push_out;
    logic [5:0]  data_out;
    logic [3:0]  umbral_af_out, umbral_ae_out;
    logic [4:0]  estado;
    logic        error_out;
    logic        idle;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_prev = 4'h0;

    pop_scheduler #(.DW(6), .N(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_af_in  (umbral_af_in),
        .umbral_ae_in  (umbral_ae_in),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .out_pause     (out_pause),
        .pop           (pop),
        .push_out      (push_out),
        .data_out      (data_out),
        .umbral_af_out (umbral_af_out),
        .umbral_ae_out (umbral_ae_out),
        .estado        (estado),
        .error_out     (error_out),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slice_of(input logic [3:0] oh);
        case (oh)
            4'b0001: slice_of = 32'd11;
            4'b0010: slice_of = 32'd22;
            4'b0100: slice_of = 32'd33;
            4'b1000: slice_of = 32'd44;
            default: slice_of = 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at edge+1; samples pop mid-cycle, lets the sources answer it
    // one cycle later, and checks the push belonging to the previous pop.
    task automatic step(input string tag, input logic [3:0] exp_pop, input logic [3:0] stray);
        logic [3:0] p;
        #3;
        p = pop;
        @(posedge clk);
        #1;
        valid_in = p | stray;
        chk({tag, "_pop"}, 32'(p), 32'(exp_pop));
        chk({tag, "_push"}, 32'(push_out), 32'(exp_prev != 4'h0));
        if (exp_prev != 4'h0) chk({tag, "_data"}, 32'(data_out), slice_of(exp_prev));
        exp_prev = exp_pop;
    endtask

    initial begin
        reset        = 1'b1;
        init         = 1'b0;
        umbral_af_in = 4'd0;
        umbral_ae_in = 4'd0;
        fifo_empty   = 4'hF;
        fifo_error   = 4'h0;
        data_in      = {6'd44, 6'd33, 6'd22, 6'd11};
        valid_in     = 4'h0;
        out_pause    = 1'b0;

        #2 reset = 1'b0;
        #1;
        chk("rst_estado", 32'(estado), 32'h01);
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push_out), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_err", 32'(error_out), 32'h0);
        chk("rst_idle", 32'(idle), 32'h0);
        chk("rst_af", 32'(umbral_af_out), 32'h0);

        @(posedge clk); #1;
        reset = 1'b1;
        step("to_init", 4'h0, 4'h0);
        chk("init_state", 32'(estado), 32'h02);
        init = 1'b1; umbral_af_in = 4'd6; umbral_ae_in = 4'd2;
        step("capture", 4'h0, 4'h0);
        init = 1'b0;
        chk("af_cap", 32'(umbral_af_out), 32'd6);
        chk("ae_cap", 32'(umbral_ae_out), 32'd2);
        chk("still_init", 32'(estado), 32'h02);
        step("to_idle", 4'h0, 4'h0);
        chk("idle_state", 32'(estado), 32'h04);
        chk("idle_flag", 32'(idle), 32'h1);

        init = 1'b1; umbral_af_in = 4'd9; umbral_ae_in = 4'd9;
        step("init_ign", 4'h0, 4'h0);
        init = 1'b0;
        chk("af_hold", 32'(umbral_af_out), 32'd6);
        chk("ae_hold", 32'(umbral_ae_out), 32'd2);

        // all four sources ready: 0,1,2,3,0
        fifo_empty = 4'h0;
        step("rr_c0", 4'h0, 4'h0);
        chk("active_state", 32'(estado), 32'h08);
        step("rr_c1", 4'b0001, 4'h0);
        step("rr_c2", 4'b0010, 4'h0);
        step("rr_c3", 4'b0100, 4'h0);
        step("rr_c4", 4'b1000, 4'h0);
        step("rr_c5", 4'b0001, 4'h0);

        // pause mid-stream: no pop, in-flight word still pushed, resume at 1
        out_pause = 1'b1;
        step("pause_c6", 4'h0, 4'h0);
        step("pause_c7", 4'h0, 4'h0);
        chk("pause_idle", 32'(estado), 32'h04);
        out_pause = 1'b0;
        step("resume_c8", 4'h0, 4'h0);
        step("resume_c9", 4'b0010, 4'h0);

        fifo_empty = 4'hF;
        step("drain_c10", 4'h0, 4'h0);
        step("drain_c11", 4'h0, 4'h0);

        // lone source 2 holding three words
        fifo_empty = 4'b1011;
        step("solo_c12", 4'h0, 4'h0);
        step("solo_c13", 4'b0100, 4'h0);
        step("solo_c14", 4'h0, 4'h0);
        step("solo_c15", 4'b0100, 4'h0);
        step("solo_c16", 4'h0, 4'h0);
        step("solo_c17", 4'b0100, 4'h0);
        fifo_empty = 4'hF;
        step("solo_c18", 4'h0, 4'h0);
        step("stray_c19", 4'h0, 4'hF);
        step("stray_c20", 4'h0, 4'h0);

        // error while active: the in-flight word is discarded
        fifo_empty = 4'h0;
        step("err_c21", 4'h0, 4'h0);
        step("err_c22", 4'b1000, 4'h0);
        fifo_error = 4'b0010;
        exp_prev   = 4'h0;
        step("err_c23", 4'h0, 4'h0);
        chk("err_state", 32'(estado), 32'h10);
        chk("err_out", 32'(error_out), 32'h1);
        fifo_error = 4'h0;
        step("err_c24", 4'h0, 4'h0);
        chk("err_sticky", 32'(estado), 32'h10);

        reset = 1'b0;
        #1;
        chk("rst2_estado", 32'(estado), 32'h01);
        chk("rst2_err", 32'(error_out), 32'h0);
        chk("rst2_af", 32'(umbral_af_out), 32'h0);
        @(posedge clk); #1;
        reset    = 1'b1;
        exp_prev = 4'h0;
        step("re_init", 4'h0, 4'h0);
        init = 1'b1; umbral_af_in = 4'd5; umbral_ae_in = 4'd3;
        step("re_cap", 4'h0, 4'h0);
        init = 1'b0;
        step("re_idle", 4'h0, 4'h0);
        chk("re_af", 32'(umbral_af_out), 32'd5);
        chk("re_ae", 32'(umbral_ae_out), 32'd3);
        step("re_c0", 4'h0, 4'h0);
        step("re_c1", 4'b0001, 4'h0);
        step("re_c2", 4'b0010, 4'h0);

        // asynchronous reset between edges with a word in flight
        #2 reset = 1'b0;
        #1;
        chk("async_estado", 32'(estado), 32'h01);
        chk("async_pop", 32'(pop), 32'h0);
        chk("async_push", 32'(push_out), 32'h0);
        chk("async_data", 32'(data_out), 32'h0);
        chk("async_idle", 32'(idle), 32'h0);
        @(posedge clk); #1;
        reset    = 1'b1;
        exp_prev = 4'h0;
        step("post_r0", 4'h0, 4'hF);
        step("post_r1", 4'h0, 4'hF);
        step("post_r2", 4'h0, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
